// File: rtl/hough_accum_ram.sv
// Vote-accumulator RAM for the Hough stage: a pipelined saturating increment port,
// a registered read port, and a sequencer that sweeps every cell back to zero.
module hough_accum_ram #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 4096,
    parameter int INC_WIDTH      = 4,
    parameter int SATURATE       = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inc_valid,
    output logic                  inc_ready,
    input  logic [ADDR_W-1:0]     inc_addr,
    input  logic [INC_WIDTH-1:0]  inc_amount,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t                  state, state_nxt;
    logic                    init_pend;
    logic [ADDR_W-1:0]       clr_addr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   bram_q;

    logic                    inc_fire;
    logic                    s2_vld, s2_hit;
    logic [ADDR_W-1:0]       s2_addr;
    logic [INC_WIDTH-1:0]    s2_amt;
    logic [DATA_WIDTH-1:0]   fwd_sum, old_val, wr_val;
    logic [DATA_WIDTH:0]     sum;

    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_WIDTH-1:0]   wdata;

    assign inc_fire = inc_valid && inc_ready;

    always_comb begin
        state_nxt  = state;
        inc_ready  = 1'b0;
        clear_busy = 1'b0;
        case (state)
            IDLE: begin
                // The power-up sweep takes priority; no increments until it is done.
                inc_ready = !init_pend;
                if (init_pend)
                    state_nxt = CLEAR;
                else if (clear_start)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                clear_busy = 1'b1;
                if (!s2_vld)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                clear_busy = 1'b1;
                if (clr_addr == LAST_ADDR)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A back-to-back hit on the same cell reads stale BRAM data; use the forwarded sum.
    always_comb begin
        old_val = s2_hit ? fwd_sum : bram_q;
        sum     = {1'b0, old_val} + (DATA_WIDTH+1)'(s2_amt);
        if (sum[DATA_WIDTH] && (SATURATE != 0))
            wr_val = '1;
        else
            wr_val = sum[DATA_WIDTH-1:0];
    end

    always_comb begin
        we    = 1'b0;
        waddr = s2_addr;
        wdata = wr_val;
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (s2_vld) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (we)
            mem[waddr] <= wdata;
        bram_q <= mem[inc_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            init_pend <= (CLEAR_ON_RESET != 0);
            clr_addr  <= '0;
            s2_vld    <= 1'b0;
            s2_hit    <= 1'b0;
            s2_addr   <= '0;
            s2_amt    <= '0;
            fwd_sum   <= '0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            init_pend <= 1'b0;
            if (state == CLEAR)
                clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
            else
                clr_addr <= '0;

            s2_vld <= inc_fire;
            s2_hit <= inc_fire && s2_vld && (inc_addr == s2_addr);
            if (inc_fire) begin
                s2_addr <= inc_addr;
                s2_amt  <= inc_amount;
            end
            fwd_sum <= wr_val;

            if (state != CLEAR && state_nxt == CLEAR)
                overflow <= 1'b0;
            else if (s2_vld && sum[DATA_WIDTH])
                overflow <= 1'b1;

            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end

endmodule
